memory_arbiter: RTL and testbench

Arbitrates the single shared memory port between the instruction-fetch requester and the data (load/store) requester of the multi-cycle RV32IM core.
- Round-robin between the two requesters when both are pending.
- Sequences the memory's fixed read latency and returns read data with a one-cycle valid pulse to the winning requester.
- Sits between the control unit/datapath and the unified instruction/data memory.

---
 rtl/memory_arbiter.sv | 137 +++++++++++++
 tb/tb_memory_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Shared memory-port arbiter for the RV32IM core: round-robin between fetch and data
// requesters, fixed read-latency sequencing, one-cycle read-data valid pulses.
module memory_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_value,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_value
);

  typedef enum logic {IDLE, READ_WAIT} state_t;
  typedef enum logic {FETCH, DATA} src_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;
  localparam logic [3:0] LAT_M1      = 4'(READ_LATENCY - 1);

  state_t      state, state_nxt;
  src_t        last_grant, last_grant_nxt;
  src_t        owner, owner_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] lat_addr, lat_addr_nxt;
  logic [2:0]  lat_funct3, lat_funct3_nxt;
  logic        rv_pend, rv_pend_nxt;
  logic        grant_fetch, grant_data, start_read;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= FETCH;
      owner      <= FETCH;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_funct3 <= FUNCT3_WORD;
      rv_pend    <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
      cnt        <= cnt_nxt;
      lat_addr   <= lat_addr_nxt;
      lat_funct3 <= lat_funct3_nxt;
      rv_pend    <= rv_pend_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    owner_nxt       = owner;
    cnt_nxt         = cnt;
    lat_addr_nxt    = lat_addr;
    lat_funct3_nxt  = lat_funct3;
    rv_pend_nxt     = 1'b0;
    grant_fetch     = 1'b0;
    grant_data      = 1'b0;
    start_read      = 1'b0;
    mem_address     = '0;
    mem_write_en    = 1'b0;
    mem_write_value = '0;
    mem_funct3      = FUNCT3_WORD;

    case (state)
      IDLE: begin
        // Readies are gated by reset so an asserted reset silences the port immediately.
        if (!reset) begin
          if (d_req && (!if_req || last_grant == FETCH)) grant_data = 1'b1;
          else if (if_req)                               grant_fetch = 1'b1;
        end
        if (grant_fetch) begin
          mem_address    = if_addr;
          last_grant_nxt = FETCH;
          owner_nxt      = FETCH;
          start_read     = 1'b1;
        end
        if (grant_data) begin
          mem_address    = d_addr;
          mem_funct3     = d_funct3;
          last_grant_nxt = DATA;
          if (d_we) begin
            mem_write_en    = 1'b1;
            mem_write_value = d_wdata;
          end else begin
            owner_nxt  = DATA;
            start_read = 1'b1;
          end
        end
        if (start_read) begin
          lat_addr_nxt   = mem_address;
          lat_funct3_nxt = mem_funct3;
          if (READ_LATENCY == 1) begin
            rv_pend_nxt = 1'b1;
          end else begin
            state_nxt = READ_WAIT;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      READ_WAIT: begin
        mem_address = lat_addr;
        mem_funct3  = lat_funct3;
        if (cnt <= 4'd1) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          rv_pend_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign if_ready  = grant_fetch;
  assign d_ready   = grant_data;
  assign if_rvalid = rv_pend && (owner == FETCH);
  assign d_rvalid  = rv_pend && (owner == DATA);
  assign if_rdata  = if_rvalid ? mem_read_value : '0;
  assign d_rdata   = d_rvalid ? mem_read_value : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter at read latencies 1 and 3.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [2:0]  d_funct3;
  logic [31:0] mem_rv1, mem_rv3;

  logic        if_ready1, if_rvalid1, d_ready1, d_rvalid1, mem_we1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wval1;
  logic [2:0]  mem_f3_1;
  logic        if_ready3, if_rvalid3, d_ready3, d_rvalid3, mem_we3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wval3;
  logic [2:0]  mem_f3_3;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_funct3(d_funct3), .d_ready(d_ready1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_address(mem_addr1), .mem_write_en(mem_we1), .mem_write_value(mem_wval1),
    .mem_funct3(mem_f3_1), .mem_read_value(mem_rv1)
  );

  memory_arbiter #(.READ_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready3),
    .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_funct3(d_funct3), .d_ready(d_ready3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_address(mem_addr3), .mem_write_en(mem_we3), .mem_write_value(mem_wval3),
    .mem_funct3(mem_f3_3), .mem_read_value(mem_rv3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; combinational outputs are sampled #2 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    int unsigned seen;
    logic exp_fetch;
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_funct3 = 3'b010;
    mem_rv1 = '0; mem_rv3 = '0;

    // Reset state, including a request that must not be granted while reset is high
    tick(); if_req = 1'b1; if_addr = 32'h10; settle();
    check("rst_if_ready", 32'(if_ready1), 32'd0);
    check("rst_d_ready", 32'(d_ready1), 32'd0);
    check("rst_rvalid", 32'({if_rvalid1, d_rvalid1}), 32'd0);
    check("rst_mem_addr", mem_addr1, 32'd0);
    check("rst_mem_we", 32'(mem_we1), 32'd0);
    check("rst_mem_f3", 32'(mem_f3_1), 32'd2);
    if_req = 1'b0;
    tick(); reset = 1'b0; settle();
    check("idle_mem_addr", mem_addr1, 32'd0);
    check("idle_mem_f3", 32'(mem_f3_1), 32'd2);

    // Fetch read, latency 1
    tick(); if_req = 1'b1; if_addr = 32'h10; settle();
    check("f1_if_ready", 32'(if_ready1), 32'd1);
    check("f1_mem_addr", mem_addr1, 32'h10);
    check("f1_mem_f3", 32'(mem_f3_1), 32'd2);
    check("f1_mem_we", 32'(mem_we1), 32'd0);
    tick(); if_req = 1'b0; mem_rv1 = 32'h93; settle();
    check("f1_if_rvalid", 32'(if_rvalid1), 32'd1);
    check("f1_if_rdata", if_rdata1, 32'h93);
    check("f1_d_rvalid", 32'(d_rvalid1), 32'd0);
    check("f1_d_rdata", d_rdata1, 32'd0);
    tick(); settle();
    check("f1_rvalid_off", 32'(if_rvalid1), 32'd0);
    check("f1_rdata_zero", if_rdata1, 32'd0);

    // Collision: data wins, then with data new pending the fetch wins the next collision
    tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_funct3 = 3'b100;
    if_req = 1'b1; if_addr = 32'h04; settle();
    check("c1_d_ready", 32'(d_ready1), 32'd1);
    check("c1_if_ready", 32'(if_ready1), 32'd0);
    check("c1_mem_addr", mem_addr1, 32'h100);
    check("c1_mem_f3", 32'(mem_f3_1), 32'd4);
    tick(); d_addr = 32'h108; mem_rv1 = 32'h1234_5678; settle();
    check("c2_d_rvalid", 32'(d_rvalid1), 32'd1);
    check("c2_d_rdata", d_rdata1, 32'h1234_5678);
    check("c2_if_ready", 32'(if_ready1), 32'd1);
    check("c2_d_ready", 32'(d_ready1), 32'd0);
    check("c2_mem_addr", mem_addr1, 32'h04);
    tick(); if_req = 1'b0; mem_rv1 = 32'h0000_AAAA; settle();
    check("c3_if_rvalid", 32'(if_rvalid1), 32'd1);
    check("c3_if_rdata", if_rdata1, 32'h0000_AAAA);
    check("c3_d_ready", 32'(d_ready1), 32'd1);
    check("c3_mem_addr", mem_addr1, 32'h108);
    tick(); d_req = 1'b0; mem_rv1 = 32'h55; settle();
    check("c4_d_rvalid", 32'(d_rvalid1), 32'd1);
    check("c4_if_rvalid", 32'(if_rvalid1), 32'd0);

    // Store: single-cycle write strobe, no rvalid, next request granted next cycle
    tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    d_funct3 = 3'b010; settle();
    check("st_d_ready", 32'(d_ready1), 32'd1);
    check("st_mem_we", 32'(mem_we1), 32'd1);
    check("st_mem_wval", mem_wval1, 32'hDEAD_BEEF);
    check("st_mem_addr", mem_addr1, 32'h200);
    tick(); d_we = 1'b0; d_addr = 32'h300; settle();
    check("st_no_rvalid", 32'(d_rvalid1), 32'd0);
    check("st_next_ready", 32'(d_ready1), 32'd1);
    check("st_we_off", 32'(mem_we1), 32'd0);
    check("st_wval_off", mem_wval1, 32'd0);
    tick(); d_req = 1'b0; settle();
    check("st_load_rvalid", 32'(d_rvalid1), 32'd1);

    // Continuous requests from both sides: last grant was DATA, so FETCH leads and they alternate
    tick(); if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_addr = 32'h400;
    exp_fetch = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      check("alt_if_ready", 32'(if_ready1), 32'(exp_fetch));
      check("alt_d_ready", 32'(d_ready1), 32'(!exp_fetch));
      exp_fetch = !exp_fetch;
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;

    // Latency 3 from a fresh reset
    reset = 1'b1; tick(); reset = 1'b0;
    tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_funct3 = 3'b000; settle();
    check("l3_d_ready", 32'(d_ready3), 32'd1);
    check("l3_mem_addr", mem_addr3, 32'h100);
    tick(); d_req = 1'b0; if_req = 1'b1; if_addr = 32'h04;
    for (int i = 1; i <= 2; i++) begin
      settle();
      check("l3_wait_ready", 32'({if_ready3, d_ready3}), 32'd0);
      check("l3_wait_addr", mem_addr3, 32'h100);
      check("l3_wait_f3", 32'(mem_f3_3), 32'd0);
      check("l3_wait_rvalid", 32'(d_rvalid3), 32'd0);
      tick();
    end
    mem_rv3 = 32'hCAFE_F00D; settle();
    check("l3_d_rvalid", 32'(d_rvalid3), 32'd1);
    check("l3_d_rdata", d_rdata3, 32'hCAFE_F00D);
    check("l3_if_ready", 32'(if_ready3), 32'd1);
    check("l3_if_addr", mem_addr3, 32'h04);
    tick(); if_req = 1'b0; settle();
    check("l3_rvalid_off", 32'(d_rvalid3), 32'd0);
    check("l3_busy_ready", 32'(if_ready3), 32'd0);
    check("l3_latched_addr", mem_addr3, 32'h04);
    tick(); tick(); mem_rv3 = 32'h0000_0013; settle();
    check("l3_if_rvalid", 32'(if_rvalid3), 32'd1);
    check("l3_if_rdata", if_rdata3, 32'h13);

    // Reset during an in-flight latency-3 read
    tick(); d_req = 1'b1; d_addr = 32'h100; settle();
    check("rr_d_ready", 32'(d_ready3), 32'd1);
    tick(); d_req = 1'b0; settle();
    check("rr_addr_held", mem_addr3, 32'h100);
    reset = 1'b1; #1;
    check("rr_addr_cleared", mem_addr3, 32'd0);
    check("rr_f3_cleared", 32'(mem_f3_3), 32'd2);
    tick(); reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      if (d_rvalid3 || if_rvalid3) seen++;
      tick();
    end
    check("rr_no_rvalid", seen, 32'd0);
    d_req = 1'b1; if_req = 1'b1; settle();
    check("rr_collision_d", 32'(d_ready3), 32'd1);
    check("rr_collision_if", 32'(if_ready3), 32'd0);
    tick(); d_req = 1'b0; if_req = 1'b0;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
